aes_ct_serializer: RTL and testbench

- Downstream stage of the AES encrypt wrapper. Consumes its registered 128-bit ciphertext and single-cycle valid pulse.
- Buffers whole blocks in a small FIFO, because the AES stage has no backpressure.
- Emits each block as OUT_W-bit words, most-significant word first, over a valid/ready stream interface toward the bus/packet side.

---
 rtl/aes_ct_serializer.sv | 162 ++++++++++++++++
 tb/tb_aes_ct_serializer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_ct_serializer.sv
// Block FIFO behind the AES encrypt stage: buffers 128-bit ciphertext blocks and
// streams each one as OUT_W-bit words, most-significant word first, over valid/ready.
module aes_ct_serializer #(
    parameter int DEPTH = 4,
    parameter int OUT_W = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         blk_valid,
    input  logic [127:0]                 blk_data,
    output logic                         out_valid,
    output logic [OUT_W-1:0]             out_data,
    output logic                         out_last,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         overflow,
    input  logic                         ovf_clr
);

    localparam int WORDS = 128 / OUT_W;
    localparam int IDX_W = $clog2(WORDS);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {
        ST_EMPTY  = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [127:0]       mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic [IDX_W-1:0]   word_idx_r, word_idx_nxt_s;
    logic [CNT_W-1:0]   fifo_count_r, fifo_count_nxt_s;
    logic               overflow_r, overflow_nxt_s;
    logic               out_valid_r, out_last_r;
    logic [OUT_W-1:0]   out_data_r;

    logic               transfer_s, pop_blk_s, accept_s, drop_s;
    logic               out_valid_nxt_s, out_last_nxt_s;
    logic [OUT_W-1:0]   out_data_nxt_s;
    logic [127:0]       head_nxt_s;
    int                 shift_s;

    // Handshake decode and next pointer/count/overflow values.
    always_comb begin
        transfer_s       = out_valid_r && out_ready;
        pop_blk_s        = transfer_s && out_last_r;
        accept_s         = blk_valid && ((fifo_count_r < CNT_W'(DEPTH)) || pop_blk_s);
        drop_s           = blk_valid && !accept_s;
        wr_ptr_nxt_s     = wr_ptr_r;
        rd_ptr_nxt_s     = rd_ptr_r;
        word_idx_nxt_s   = word_idx_r;
        fifo_count_nxt_s = fifo_count_r;
        overflow_nxt_s   = overflow_r;
        if (accept_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_blk_s) begin
            rd_ptr_nxt_s   = rd_ptr_r + PTR_W'(1);
            word_idx_nxt_s = IDX_W'(0);
        end else if (transfer_s) begin
            word_idx_nxt_s = word_idx_r + IDX_W'(1);
        end else begin
            word_idx_nxt_s = word_idx_r;
        end
        case ({accept_s, pop_blk_s})
            2'b10:   fifo_count_nxt_s = fifo_count_r + CNT_W'(1);
            2'b01:   fifo_count_nxt_s = fifo_count_r - CNT_W'(1);
            default: fifo_count_nxt_s = fifo_count_r;
        endcase
        // A drop in the same cycle as a clear request wins.
        if (drop_s) begin
            overflow_nxt_s = 1'b1;
        end else if (ovf_clr) begin
            overflow_nxt_s = 1'b0;
        end else begin
            overflow_nxt_s = overflow_r;
        end
    end

    // Control FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_nxt_s = ST_STREAM;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_STREAM: begin
                if (pop_blk_s && !accept_s && (fifo_count_r == CNT_W'(1))) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end
            default: state_nxt_s = ST_EMPTY;
        endcase
    end

    // Next output word; the head comes straight from blk_data when it is being written now.
    always_comb begin
        out_valid_nxt_s = (state_nxt_s == ST_STREAM);
        if (accept_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
            head_nxt_s = blk_data;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
        shift_s = (WORDS - 1 - int'(word_idx_nxt_s)) * OUT_W;
        if (out_valid_nxt_s) begin
            out_data_nxt_s = OUT_W'(head_nxt_s >> shift_s);
            out_last_nxt_s = (word_idx_nxt_s == IDX_W'(WORDS - 1));
        end else begin
            out_data_nxt_s = '0;
            out_last_nxt_s = 1'b0;
        end
    end

    // Block storage, intentionally not reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= blk_data;
        end
    end

    // Control state, pointers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_EMPTY;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            word_idx_r   <= '0;
            fifo_count_r <= '0;
            overflow_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            out_data_r   <= '0;
        end else begin
            state_r      <= state_nxt_s;
            wr_ptr_r     <= wr_ptr_nxt_s;
            rd_ptr_r     <= rd_ptr_nxt_s;
            word_idx_r   <= word_idx_nxt_s;
            fifo_count_r <= fifo_count_nxt_s;
            overflow_r   <= overflow_nxt_s;
            out_valid_r  <= out_valid_nxt_s;
            out_last_r   <= out_last_nxt_s;
            out_data_r   <= out_data_nxt_s;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_last   = out_last_r;
    assign fifo_count = fifo_count_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_aes_ct_serializer.sv
// Directed and randomized bench for aes_ct_serializer against a queue-based block model.
module tb_aes_ct_serializer;

    localparam int DEPTH = 4;
    localparam int OUT_W = 32;
    localparam int WORDS = 128 / OUT_W;

    logic               clk = 1'b0;
    logic               reset;
    logic               blk_valid;
    logic [127:0]       blk_data;
    logic               out_valid;
    logic [OUT_W-1:0]   out_data;
    logic               out_last;
    logic               out_ready;
    logic [2:0]         fifo_count;
    logic               overflow;
    logic               ovf_clr;

    int total = 0;
    int passed = 0;
    int xfer_cnt = 0;

    logic [127:0] mq [$];
    int           widx = 0;
    bit           movf = 1'b0;

    aes_ct_serializer #(.DEPTH(DEPTH), .OUT_W(OUT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .blk_valid  (blk_valid),
        .blk_data   (blk_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [OUT_W-1:0] exp_word();
        logic [127:0] blk;
        if (mq.size() == 0) return '0;
        blk = mq[0];
        return blk[127 - widx * OUT_W -: OUT_W];
    endfunction

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Check the DUT against the model, then advance one clock and update the model.
    task automatic step();
        bit v, xf, lst, pop, acc;
        chk("out_valid", {127'b0, out_valid}, {127'b0, mq.size() > 0});
        chk("out_data", {96'b0, out_data}, {96'b0, exp_word()});
        chk("out_last", {127'b0, out_last}, {127'b0, (mq.size() > 0) && (widx == WORDS - 1)});
        chk("fifo_count", {125'b0, fifo_count}, 128'(mq.size()));
        chk("overflow", {127'b0, overflow}, {127'b0, movf});
        if (out_valid && out_ready) xfer_cnt++;
        @(posedge clk);
        v   = mq.size() > 0;
        xf  = v && out_ready;
        lst = (widx == WORDS - 1);
        pop = xf && lst;
        acc = blk_valid && ((mq.size() < DEPTH) || pop);
        if (xf) widx = lst ? 0 : widx + 1;
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(blk_data);
        if (blk_valid && !acc) movf = 1'b1;
        else if (ovf_clr) movf = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bit pat [7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        reset = 1'b0; blk_valid = 1'b0; blk_data = '0; out_ready = 1'b0; ovf_clr = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_valid", {127'b0, out_valid}, 128'd0);
        chk("rst_data", {96'b0, out_data}, 128'd0);
        chk("rst_count", {125'b0, fifo_count}, 128'd0);
        chk("rst_ovf", {127'b0, overflow}, 128'd0);
        reset = 1'b1;
        step();

        // 1: basic order
        out_ready = 1'b1;
        blk_valid = 1'b1; blk_data = 128'h3925841d02dc09fbdc118597196a0b32;
        step();
        blk_valid = 1'b0;
        chk("t1_w0", {96'b0, out_data}, 128'h3925841d);
        step(); step(); step();
        chk("t1_w3", {96'b0, out_data}, 128'h196a0b32);
        chk("t1_last", {127'b0, out_last}, 128'd1);
        step(); step(); step();

        // 2: backpressure
        xfer_cnt = 0;
        out_ready = 1'b0;
        blk_valid = 1'b1;
        step();
        blk_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            out_ready = pat[i];
            step();
        end
        chk("t2_xfers", 128'(xfer_cnt), 128'd4);
        out_ready = 1'b1;
        step(); step();

        // 3: overflow
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            blk_valid = 1'b1; blk_data = 128'(i);
            step();
        end
        blk_valid = 1'b0;
        chk("t3_count", {125'b0, fifo_count}, 128'd4);
        chk("t3_ovf", {127'b0, overflow}, 128'd1);
        out_ready = 1'b1;
        repeat (18) step();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("t3_clr", {127'b0, overflow}, 128'd0);

        // 4: simultaneous retire + write while full
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            blk_valid = 1'b1; blk_data = rand_blk();
            step();
        end
        blk_valid = 1'b0;
        out_ready = 1'b1;
        step(); step(); step();
        chk("t4_last", {127'b0, out_last}, 128'd1);
        blk_valid = 1'b1; blk_data = rand_blk();
        step();
        blk_valid = 1'b0;
        chk("t4_count", {125'b0, fifo_count}, 128'd4);
        chk("t4_ovf", {127'b0, overflow}, 128'd0);
        repeat (18) step();

        // 5: reset mid-stream
        blk_valid = 1'b1; blk_data = rand_blk();
        step();
        blk_valid = 1'b0;
        step(); step();
        reset = 1'b0;
        #1;
        chk("t5_valid", {127'b0, out_valid}, 128'd0);
        chk("t5_data", {96'b0, out_data}, 128'd0);
        chk("t5_last", {127'b0, out_last}, 128'd0);
        chk("t5_count", {125'b0, fifo_count}, 128'd0);
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        mq.delete(); widx = 0; movf = 1'b0;
        repeat (3) step();
        blk_valid = 1'b1; blk_data = 128'hcafef00d_11111111_22222222_33333333;
        step();
        blk_valid = 1'b0;
        chk("t5_w0", {96'b0, out_data}, 128'hcafef00d);
        repeat (5) step();

        // 6: back-to-back blocks through pointer wrap
        xfer_cnt = 0;
        for (int b = 0; b < 10; b++) begin
            blk_valid = 1'b1; blk_data = rand_blk();
            step();
            blk_valid = 1'b0;
            step(); step(); step();
        end
        repeat (6) step();
        chk("t6_xfers", 128'(xfer_cnt), 128'd40);
        chk("t6_ovf", {127'b0, overflow}, 128'd0);
        chk("t6_count", {125'b0, fifo_count}, 128'd0);

        // Randomized traffic, alternating light and heavy backpressure.
        for (int i = 0; i < 400; i++) begin
            blk_valid = ($urandom_range(0, 2) == 0);
            blk_data  = rand_blk();
            out_ready = (i % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            step();
        end
        blk_valid = 1'b0; ovf_clr = 1'b0; out_ready = 1'b1;
        repeat (20) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
